// File: rtl/voice_change_fifo_pkg.sv
// rtl/voice_change_fifo_pkg.sv - shared sizes and types for the voice-change sample FIFO
package voice_change_fifo_pkg;
  localparam int DEPTH_WIDTH      = 11;
  localparam int DATA_WIDTH       = 16;
  localparam int DEPTH            = 2 ** DEPTH_WIDTH;
  localparam int ALMOST_FULL_NUM  = 1020;
  localparam int ALMOST_EMPTY_NUM = 4;

  typedef logic [DATA_WIDTH-1:0]  data_t;
  typedef logic [DEPTH_WIDTH:0]   level_t;
  typedef logic [DEPTH_WIDTH-1:0] ptr_t;
endpackage

// File: rtl/voice_change_fifo_ram.sv
// rtl/voice_change_fifo_ram.sv - simple dual-port sample RAM, synchronous registered read
module voice_change_fifo_ram
  import voice_change_fifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DEPTH_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  input  logic [DEPTH_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/voice_change_fifo.sv
// rtl/voice_change_fifo.sv - 2048x16 standard-read FIFO with registered flags and water levels
// Optional VOICE_FIFO_OUTPUT_REG_EN adds an output register on rd_data (read latency 2).
module voice_change_fifo
  import voice_change_fifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_en,
  output logic                   wr_full,
  output logic [DEPTH_WIDTH:0]   wr_water_level,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic [DEPTH_WIDTH:0]   rd_water_level,
  output logic                   almost_empty
);
  ptr_t   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  level_t count_q, count_d;
  logic   wr_full_q, rd_empty_q, almost_full_q, almost_empty_q;
  logic   wr_acc, rd_acc;
  data_t  ram_rd_data;

  assign wr_acc = wr_en && !wr_full_q;
  assign rd_acc = rd_en && !rd_empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + level_t'(1);
      2'b01:   count_d = count_q - level_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags come from the next count so they line up with count_q every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      wr_full_q      <= (count_d == level_t'(DEPTH));
      rd_empty_q     <= (count_d == '0);
      almost_full_q  <= (count_d >= level_t'(ALMOST_FULL_NUM));
      almost_empty_q <= (count_d <= level_t'(ALMOST_EMPTY_NUM));
    end
  end

  voice_change_fifo_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

`ifdef VOICE_FIFO_OUTPUT_REG_EN
  data_t rd_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_out_q <= '0;
    end else begin
      rd_out_q <= ram_rd_data;
    end
  end

  assign rd_data = rd_out_q;
`else
  assign rd_data = ram_rd_data;
`endif

  assign wr_full        = wr_full_q;
  assign rd_empty       = rd_empty_q;
  assign almost_full    = almost_full_q;
  assign almost_empty   = almost_empty_q;
  assign wr_water_level = count_q;
  assign rd_water_level = count_q;
endmodule

// File: tb/tb_voice_change_fifo.sv
// tb/tb_voice_change_fifo.sv - self-checking bench for voice_change_fifo
module tb_voice_change_fifo;
  import voice_change_fifo_pkg::*;

`ifdef VOICE_FIFO_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic [11:0] wr_water_level;
  logic        almost_full;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_empty;
  logic [11:0] rd_water_level;
  logic        almost_empty;

  always #5 clk = ~clk;

  voice_change_fifo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] q[$];
  logic [15:0] m_ram = 16'h0;
  logic [15:0] m_out = 16'h0;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] wd;
    int          lvl;
    logic        empty;
    logic        ae;
    logic [15:0] rdd;
  } vec_t;
  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] vis();
    return (LAT == 1) ? m_ram : m_out;
  endfunction

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, "_wlevel"}, 32'(wr_water_level), 32'(n));
    chk({tag, "_rlevel"}, 32'(rd_water_level), 32'(n));
    chk({tag, "_full"}, 32'(wr_full), 32'(n == DEPTH));
    chk({tag, "_empty"}, 32'(rd_empty), 32'(n == 0));
    chk({tag, "_afull"}, 32'(almost_full), 32'(n >= ALMOST_FULL_NUM));
    chk({tag, "_aempty"}, 32'(almost_empty), 32'(n <= ALMOST_EMPTY_NUM));
    chk({tag, "_rdata"}, 32'(rd_data), 32'(vis()));
  endtask

  // One clock: drive at negedge, update reference model at posedge, sample 1ns later.
  task automatic step(input logic we, input logic [15:0] wd, input logic re, input string tag);
    logic [15:0] old;
    int n;
    @(negedge clk);
    wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk);
    old = m_ram;
    if (!rst_n) begin
      q.delete();
      m_ram = 16'h0;
      m_out = 16'h0;
    end else begin
      n = q.size();
      if (re && n > 0) m_ram = q.pop_front();
      if (we && n < DEPTH) q.push_back(wd);
      m_out = old;
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [15:0] e_prev, e_cur, keep;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0;

    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, "rst");
    chk("rst_empty", 32'(rd_empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(wr_full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_level", 32'(wr_water_level), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    rst_n = 1'b1;

    tv[0]  = '{1'b1, 1'b0, 16'h1234, 1, 1'b0, 1'b1, 16'h0000};
    tv[1]  = '{1'b1, 1'b0, 16'h5678, 2, 1'b0, 1'b1, 16'h0000};
    tv[2]  = '{1'b1, 1'b1, 16'h9ABC, 2, 1'b0, 1'b1, 16'h1234};
    tv[3]  = '{1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b1, 16'h5678};
    tv[4]  = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b1, 16'h9ABC};
    tv[5]  = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b1, 16'h9ABC};
    tv[6]  = '{1'b1, 1'b1, 16'h1111, 1, 1'b0, 1'b1, 16'h9ABC};
    tv[7]  = '{1'b1, 1'b0, 16'h2222, 2, 1'b0, 1'b1, 16'h9ABC};
    tv[8]  = '{1'b1, 1'b0, 16'h3333, 3, 1'b0, 1'b1, 16'h9ABC};
    tv[9]  = '{1'b1, 1'b0, 16'h4444, 4, 1'b0, 1'b1, 16'h9ABC};
    tv[10] = '{1'b1, 1'b0, 16'h5555, 5, 1'b0, 1'b0, 16'h9ABC};
    tv[11] = '{1'b0, 1'b1, 16'h0000, 4, 1'b0, 1'b1, 16'h1111};
    tv[12] = '{1'b0, 1'b0, 16'h0000, 4, 1'b0, 1'b1, 16'h1111};
    e_prev = 16'h0000;
    for (int i = 0; i < 13; i++) begin
      step(tv[i].we, tv[i].wd, tv[i].re, "vec_model");
      chk($sformatf("vec%0d_level", i), 32'(wr_water_level), 32'(tv[i].lvl));
      chk($sformatf("vec%0d_empty", i), 32'(rd_empty), 32'(tv[i].empty));
      chk($sformatf("vec%0d_aempty", i), 32'(almost_empty), 32'(tv[i].ae));
      chk($sformatf("vec%0d_rdata", i), 32'(rd_data), 32'((LAT == 1) ? tv[i].rdd : e_prev));
      e_prev = tv[i].rdd;
    end

    rst_n = 1'b0;
    step(1'b0, 16'h0, 1'b0, "rst2");
    rst_n = 1'b1;
    for (int k = 1; k <= 2049; k++) begin
      step(1'b1, 16'hFFFF - 16'(k - 1), 1'b0, "fill_model");
      chk("fill_level", 32'(wr_water_level), 32'((k <= 2048) ? k : 2048));
      chk("fill_afull", 32'(almost_full), 32'(k >= 1020));
      chk("fill_full", 32'(wr_full), 32'(k >= 2048));
    end

    e_prev = m_ram;
    for (int k = 1; k <= 2049; k++) begin
      step(1'b0, 16'h0, 1'b1, "drain_model");
      e_cur = (k <= 2048) ? 16'hFFFF - 16'(k - 1) : 16'hF800;
      chk("drain_rdata", 32'(rd_data), 32'((LAT == 1) ? e_cur : e_prev));
      chk("drain_level", 32'(rd_water_level), 32'((k <= 2048) ? 2048 - k : 0));
      chk("drain_aempty", 32'(almost_empty), 32'((2048 - k) <= 4));
      chk("drain_empty", 32'(rd_empty), 32'(k >= 2048));
      e_prev = e_cur;
    end
    step(1'b0, 16'h0, 1'b0, "drain_hold");
    chk("drain_hold_rdata", 32'(rd_data), 32'h0000F800);

    for (int i = 0; i < 10; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0, "conc_pre");
    chk("conc_start_level", 32'(wr_water_level), 32'd10);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 16'hB000 + 16'(i), 1'b1, "conc_model");
      chk("conc_level", 32'(wr_water_level), 32'd10);
      e_cur = (i < 10) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i - 10);
      if (i >= LAT - 1)
        chk("conc_rdata", 32'(rd_data), 32'((LAT == 1) ? e_cur : ((i < 11) ? 16'hA000 + 16'(i - 1) : 16'hB000 + 16'(i - 11))));
    end

    rst_n = 1'b0;
    step(1'b0, 16'h0, 1'b0, "rst3");
    rst_n = 1'b1;
    for (int i = 0; i < 2048; i++) step(1'b1, 16'(i), 1'b0, "full_pre");
    chk("bnd_full_before", 32'(wr_full), 32'd1);
    step(1'b1, 16'hDEAD, 1'b1, "bnd_full_model");
    chk("bnd_full_level", 32'(wr_water_level), 32'd2047);
    chk("bnd_full_flag", 32'(wr_full), 32'd0);
    for (int i = 0; i < 2047; i++) step(1'b0, 16'h0, 1'b1, "bnd_drain");
    chk("bnd_empty_before", 32'(rd_empty), 32'd1);
    step(1'b0, 16'h0, 1'b0, "bnd_settle");
    keep = vis();
    step(1'b1, 16'h7777, 1'b1, "bnd_empty_model");
    chk("bnd_empty_level", 32'(wr_water_level), 32'd1);
    chk("bnd_empty_rdata", 32'(rd_data), 32'(keep));
    step(1'b0, 16'h0, 1'b1, "bnd_read");
    step(1'b0, 16'h0, 1'b0, "bnd_idle");
    chk("bnd_written_word", 32'(rd_data), 32'h00007777);

    for (int i = 0; i < 500; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, "mid_fill");
    chk("mid_level", 32'(wr_water_level), 32'd500);
    rst_n = 1'b0;
    step(1'b1, 16'h9999, 1'b0, "mid_rst");
    rst_n = 1'b1;
    chk("mid_rst_level", 32'(wr_water_level), 32'd0);
    chk("mid_rst_empty", 32'(rd_empty), 32'd1);
    step(1'b1, 16'h4242, 1'b0, "mid_wr");
    step(1'b0, 16'h0, 1'b1, "mid_rd");
    step(1'b0, 16'h0, 1'b0, "mid_idle");
    chk("mid_new_word", 32'(rd_data), 32'h00004242);
    chk("mid_end_empty", 32'(rd_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
